// File: rtl/spi_motor_scheduler.sv
// Round-robin scheduler sharing one SPI transfer path among motor boards.
// Sequences select, start, wait-for-done/timeout and gap for each enabled motor.
module spi_motor_scheduler #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int SETUP_CYCLES     = 4,
    parameter int GAP_CYCLES       = 50,
    parameter int TIMEOUT_CYCLES   = 5000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        single_pass,
    input  logic [NUMBER_OF_MOTORS-1:0] motor_enable,
    input  logic                        spi_done,
    input  logic                        spi_ssel_i,
    output logic                        start,
    output logic [3:0]                  motor_index,
    output logic [NUMBER_OF_MOTORS-1:0] ss_n,
    output logic                        busy,
    output logic                        pass_done,
    output logic [NUMBER_OF_MOTORS-1:0] timeout_error
);

    localparam int N = NUMBER_OF_MOTORS;
    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic           one_shot_q, one_shot_d;
    logic           start_q, start_d;
    logic           busy_q, busy_d;
    logic           pass_done_q, pass_done_d;
    logic [N-1:0]   terr_q, terr_d;

    logic [3:0]     first_idx;
    logic [3:0]     next_idx;
    logic           next_found;
    logic [N-1:0]   idx_sel;

    // Lowest enabled motor, and lowest enabled motor above the current index
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        idx_sel    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (motor_enable[i]) begin
                first_idx = 4'(i);
                if (4'(i) > idx_q) begin
                    next_idx   = 4'(i);
                    next_found = 1'b1;
                end
            end
            if (4'(i) == idx_q) begin
                idx_sel[i] = 1'b1;
            end
        end
    end

    // Next-state logic for the sequencer and its counters and flags
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        one_shot_d  = one_shot_q;
        terr_d      = terr_q;
        pass_done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if ((enable | single_pass) && (|motor_enable)) begin
                    state_d    = S_SELECT;
                    idx_d      = first_idx;
                    cnt_d      = '0;
                    one_shot_d = single_pass & ~enable;
                end
            end
            S_SELECT: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_START: begin
                state_d = S_WAIT_DONE;
                cnt_d   = '0;
            end
            S_WAIT_DONE: begin
                if (spi_done) begin
                    terr_d  = terr_q & ~idx_sel;
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    terr_d  = terr_q | idx_sel;
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (next_found) begin
                        idx_d   = next_idx;
                        state_d = S_SELECT;
                    end else begin
                        pass_done_d = 1'b1;
                        if (one_shot_q || !enable || (motor_enable == '0)) begin
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = first_idx;
                            state_d = S_SELECT;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    // State, counter and registered output flops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            one_shot_q  <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
            terr_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            one_shot_q  <= one_shot_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            pass_done_q <= pass_done_d;
            terr_q      <= terr_d;
        end
    end

    // Route spi_master's select only to the active motor while transferring
    always_comb begin
        ss_n = '1;
        if ((state_q == S_START) || (state_q == S_WAIT_DONE)) begin
            for (int i = 0; i < N; i++) begin
                if (idx_sel[i]) begin
                    ss_n[i] = spi_ssel_i;
                end
            end
        end
    end

    assign start         = start_q;
    assign motor_index   = idx_q;
    assign busy          = busy_q;
    assign pass_done     = pass_done_q;
    assign timeout_error = terr_q;

endmodule

// File: tb/tb_spi_motor_scheduler.sv
// Directed bench for spi_motor_scheduler with a delayed-done responder.
// Start pulses and pass_done pulses are logged with cycle stamps.
module tb_spi_motor_scheduler;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       single_pass;
    logic [5:0] motor_enable;
    logic       spi_done;
    logic       spi_ssel_i;
    logic       start;
    logic [3:0] motor_index;
    logic [5:0] ss_n;
    logic       busy;
    logic       pass_done;
    logic [5:0] timeout_error;

    spi_motor_scheduler #(
        .NUMBER_OF_MOTORS(6),
        .SETUP_CYCLES(4),
        .GAP_CYCLES(50),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .single_pass(single_pass),
        .motor_enable(motor_enable),
        .spi_done(spi_done),
        .spi_ssel_i(spi_ssel_i),
        .start(start),
        .motor_index(motor_index),
        .ss_n(ss_n),
        .busy(busy),
        .pass_done(pass_done),
        .timeout_error(timeout_error)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int nlog = 0;
    int lidx [64];
    int ltim [64];
    int npass = 0;
    int pidx [64];
    int ptim [64];

    logic [5:0] respond = 6'b111111;
    int delay = 40;
    int dcnt = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc = cyc + 1;

    // Log start and pass_done pulses
    always begin
        @(posedge clock);
        #1;
        if (start && nlog < 64) begin
            lidx[nlog] = int'(motor_index);
            ltim[nlog] = cyc;
            nlog = nlog + 1;
        end
        if (pass_done && npass < 64) begin
            pidx[npass] = int'(motor_index);
            ptim[npass] = cyc;
            npass = npass + 1;
        end
    end

    // SpiControl stand-in: done pulse `delay` cycles after start
    always begin
        @(posedge clock);
        #1;
        spi_done = 1'b0;
        if (dcnt > 0) begin
            dcnt = dcnt - 1;
            if (dcnt == 0) spi_done = 1'b1;
        end
        if (start && respond[motor_index[2:0]]) dcnt = delay;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (nlog < n && k < budget) begin
            step();
            k++;
        end
        check("wait_log", 32'(nlog >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic clear_logs();
        nlog = 0;
        npass = 0;
    endtask

    initial begin
        int r;
        int s;
        reset_n = 1'b0;
        enable = 1'b0;
        single_pass = 1'b0;
        motor_enable = 6'b111111;
        spi_done = 1'b0;
        spi_ssel_i = 1'b1;
        repeat (3) step();

        check("rst_start", 32'(start), 32'd0);
        check("rst_index", 32'(motor_index), 32'd0);
        check("rst_ss_n", 32'(ss_n), 32'h3f);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pass", 32'(pass_done), 32'd0);
        check("rst_terr", 32'(timeout_error), 32'd0);

        reset_n = 1'b1;
        repeat (2) step();

        // continuous run over all six motors
        clear_logs();
        r = cyc;
        enable = 1'b1;
        wait_log(7, 1000);
        check("t1_latency", 32'(ltim[0] - r), 32'd5);
        for (int i = 0; i < 7; i++) begin
            check("t1_order", 32'(lidx[i]), 32'(i % 6));
        end
        check("t1_spacing", 32'(ltim[1] - ltim[0]), 32'd95);
        check("t1_spacing5", 32'(ltim[6] - ltim[5]), 32'd95);
        check("t1_npass", 32'(npass), 32'd1);
        check("t1_pass_time", 32'(ptim[0]), 32'(ltim[6] - 4));
        check("t1_pass_idx", 32'(pidx[0]), 32'd0);
        enable = 1'b0;
        wait_idle(1500);

        // one pass over a sparse mask
        clear_logs();
        motor_enable = 6'b100101;
        single_pass = 1'b1;
        step();
        single_pass = 1'b0;
        wait_idle(1000);
        repeat (100) step();
        check("t2_nstarts", 32'(nlog), 32'd3);
        check("t2_idx0", 32'(lidx[0]), 32'd0);
        check("t2_idx1", 32'(lidx[1]), 32'd2);
        check("t2_idx2", 32'(lidx[2]), 32'd5);
        check("t2_npass", 32'(npass), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);

        // motor 3 silent: timeout flag, then cleared next pass
        clear_logs();
        motor_enable = 6'b111111;
        respond = 6'b110111;
        enable = 1'b1;
        wait_log(4, 1000);
        check("t3_idx3", 32'(lidx[3]), 32'd3);
        s = ltim[3];
        wait_cyc(s + 100);
        check("t3_terr_pre", 32'(timeout_error), 32'h00);
        wait_cyc(s + 101);
        check("t3_terr_set", 32'(timeout_error), 32'h08);
        respond = 6'b111111;
        wait_log(5, 1000);
        check("t3_next_idx", 32'(lidx[4]), 32'd4);
        check("t3_to_spacing", 32'(ltim[4] - ltim[3]), 32'd155);
        wait_log(10, 1500);
        check("t3_idx3_again", 32'(lidx[9]), 32'd3);
        s = ltim[9];
        wait_cyc(s + 40);
        check("t3_terr_hold", 32'(timeout_error), 32'h08);
        wait_cyc(s + 41);
        check("t3_terr_clr", 32'(timeout_error), 32'h00);
        enable = 1'b0;
        wait_idle(1500);

        // single motor: timeout, then done coincident with expiry
        clear_logs();
        motor_enable = 6'b000001;
        respond = 6'b000000;
        single_pass = 1'b1;
        step();
        single_pass = 1'b0;
        wait_idle(600);
        check("t4_terr_set", 32'(timeout_error), 32'h01);
        check("t4_npass", 32'(npass), 32'd1);
        check("t4_nstarts", 32'(nlog), 32'd1);
        respond = 6'b000001;
        delay = 100;
        single_pass = 1'b1;
        step();
        single_pass = 1'b0;
        wait_idle(600);
        check("t4_coincident", 32'(timeout_error), 32'h00);
        check("t4_npass2", 32'(npass), 32'd2);

        // reset during WAIT_DONE of motor 2
        clear_logs();
        delay = 40;
        respond = 6'b111111;
        motor_enable = 6'b111111;
        enable = 1'b1;
        wait_log(3, 1000);
        wait_cyc(ltim[2] + 10);
        check("t5_index", 32'(motor_index), 32'd2);
        spi_ssel_i = 1'b0;
        #1;
        check("t5_ss_active", 32'(ss_n), 32'h3b);
        reset_n = 1'b0;
        dcnt = 0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_index", 32'(motor_index), 32'd0);
        check("t5_rst_ss_n", 32'(ss_n), 32'h3f);
        check("t5_rst_start", 32'(start), 32'd0);
        clear_logs();
        repeat (3) step();
        check("t5_no_start", 32'(nlog), 32'd0);
        spi_ssel_i = 1'b1;
        reset_n = 1'b1;
        wait_log(1, 200);
        check("t5_first_idx", 32'(lidx[0]), 32'd0);

        // ss_n gating around motor 4
        wait_log(4, 1000);
        s = ltim[3];
        wait_cyc(s + 60);
        spi_ssel_i = 1'b0;
        #1;
        check("t6_ss_gap", 32'(ss_n), 32'h3f);
        wait_cyc(s + 92);
        check("t6_sel_idx", 32'(motor_index), 32'd4);
        check("t6_ss_select", 32'(ss_n), 32'h3f);
        wait_cyc(s + 100);
        check("t6_ss_low", 32'(ss_n), 32'h2f);
        spi_ssel_i = 1'b1;
        #1;
        check("t6_ss_high", 32'(ss_n), 32'h3f);
        spi_ssel_i = 1'b0;
        #1;
        check("t6_ss_low2", 32'(ss_n), 32'h2f);
        spi_ssel_i = 1'b1;
        enable = 1'b0;
        wait_idle(1500);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_motor_scheduler.md
Name: spi_motor_scheduler

Overview:
- Round-robin sequencer that shares the single SpiControl/spi_master transfer path among NUMBER_OF_MOTORS motor boards.
- For each enabled motor it:
  - selects the motor index, which drives the SSN mux and the data-word selection upstream;
  - pulses start to SpiControl;
  - waits for SpiControl done, or times out;
  - inserts an inter-frame gap, then advances to the next motor.
- Runs continuously when enabled, or performs one pass on request.

Parameters:
- NUMBER_OF_MOTORS, 6: number of slave boards; legal range 1..16.
- SETUP_CYCLES, 4: clocks between index change and start pulse, so the mux and data path settle.
- GAP_CYCLES, 50: clocks of idle between the end of one transfer and the next index change.
- TIMEOUT_CYCLES, 5000: clocks to wait for spi_done before declaring an error; range 1..65535.

Ports:
- clock  in  1  system clock (FPGA_CLK1_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = cycle continuously through enabled motors.
- single_pass  in  1  one-cycle pulse; run exactly one pass over enabled motors, then return to IDLE.
- motor_enable  in  NUMBER_OF_MOTORS  bit i = 1 includes motor i in the schedule; sampled at each index advance.
- spi_done  in  1  one-cycle pulse from SpiControl at transfer completion.
- spi_ssel_i  in  1  slave-select from spi_master, active low.
- start  out  1  one-cycle pulse to SpiControl.
- motor_index  out  4  currently selected motor; bits above clog2(N) are 0.
- ss_n  out  NUMBER_OF_MOTORS  per-motor select, active low.
  - ss_n[motor_index] = spi_ssel_i while state is START or WAIT_DONE.
  - All other bits are 1. Combinational from the registered state and index.
- busy  out  1  1 in any state other than IDLE.
- pass_done  out  1  one-cycle pulse when the last enabled motor of a pass finishes its gap.
- timeout_error  out  NUMBER_OF_MOTORS  sticky per-motor flags.
  - Bit i is set on timeout of motor i.
  - Bit i is cleared when motor i later completes a transfer with spi_done.

Behaviour:
- Reset values: state IDLE, start 0, motor_index 0, ss_n all 1, busy 0, pass_done 0, timeout_error all 0, all counters 0. Reset mid-transfer aborts immediately; no start pulse follows release.
- States: IDLE, SELECT, START, WAIT_DONE, GAP.
- IDLE:
  - Leave IDLE when (enable | single_pass) and motor_enable != 0.
  - On leaving, load motor_index with the lowest set bit of motor_enable, clear the counter, go to SELECT.
  - Latch an internal one_shot flag = single_pass & ~enable.
  - If motor_enable == 0, stay in IDLE and drop the request.
- SELECT: count SETUP_CYCLES clocks, then go to START.
- START:
  - start = 1 for exactly this one cycle.
  - Next state WAIT_DONE; the timeout counter is cleared.
- WAIT_DONE:
  - On spi_done: clear timeout_error[motor_index], go to GAP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: set timeout_error[motor_index], go to GAP.
  - If spi_done and timeout occur on the same cycle, done wins and the flag is cleared.
- GAP:
  - Count GAP_CYCLES clocks, then advance.
  - Next index = next set bit of motor_enable strictly above motor_index, wrapping to the lowest set bit.
  - A wrap, or no higher bit, marks the end of the pass and pulses pass_done in the same cycle as the advance.
- End of pass:
  - If one_shot is set, or enable = 0, or motor_enable = 0: go to IDLE (index is retained).
  - Otherwise go to SELECT with the new index.
  - Single enabled motor: every advance is a pass end, and the same index is reselected.
- enable dropping mid-pass: the current pass completes; no transfer is ever truncated.
- single_pass while busy: ignored.
- motor_enable changes mid-transfer: take effect only at the next advance. The current transfer completes even if its own bit was cleared.
- Latency, IDLE to start pulse: 1 + SETUP_CYCLES clocks after the request cycle.
- Per-motor slot: SETUP_CYCLES + 1 + transfer + GAP_CYCLES clocks.

Test Plan:
- N=6, mask 6'b111111, enable=1, bench returns spi_done 40 clocks after each start:
  - start pulses occur for indices 0,1,2,3,4,5,0…;
  - start-to-start spacing is 4+1+40+50 = 95 clocks, measured as start→done 40, +50 gap, +4 setup, +1;
  - pass_done pulses once per 6 transfers, coincident with the 5→0 advance.
- Mask 6'b100101, single_pass pulse, enable=0: exactly three start pulses at indices 0, 2, 5; one pass_done; then busy = 0 and state IDLE.
- TIMEOUT_CYCLES=100, motor 3 never returns spi_done:
  - timeout_error = 6'b001000 after 100 clocks in WAIT_DONE, and the schedule continues to motor 4;
  - the next pass, with done present, clears bit 3.
- spi_done asserted in the same cycle the timeout counter expires: timeout_error bit stays 0.
- reset_n pulled low during WAIT_DONE of motor 2:
  - all outputs return to reset values asynchronously; ss_n = all 1s;
  - after release with enable=1, the first start is for motor 0.
- ss_n gating with spi_ssel_i toggling during WAIT_DONE of motor 4: only ss_n[4] follows it; the other bits stay 1, including during SELECT and GAP.
